// File: rtl/lfsr_checker.sv
// Receive-side checker for a 32-bit right-shift Galois LFSR pattern: self-seeds, locks, counts errors.
// Optional word counter enabled by defining LFSR_CHK_WORD_CNT_EN.
`timescale 1ns/1ps
module lfsr_checker #(
  parameter logic [31:0] POLY_MASK    = 32'hB4000000,
  parameter int          LOCK_MATCHES = 4,
  parameter int          LOSS_MISSES  = 8,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [31:0]      data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_WORD_CNT_EN
  ,
  output logic [31:0]      word_count
`endif
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LM = 4'(LOCK_MATCHES);
  localparam logic [7:0] LX = 8'(LOSS_MISSES);

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ POLY_MASK) : (x >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic [31:0]      r_pred;
  logic [3:0]       r_match_cnt;
  logic [7:0]       r_miss_cnt;
  logic             r_locked;
  logic             r_err_pulse;
  logic             r_lock_lost;
  logic [CNT_W-1:0] r_err_count;

  logic             w_match;
  logic [3:0]       w_match_inc;
  logic [7:0]       w_miss_inc;
  logic             w_locked_miss;

  assign w_match       = (data_in == r_pred);
  assign w_match_inc   = r_match_cnt + 4'd1;
  assign w_miss_inc    = r_miss_cnt + 8'd1;
  assign w_locked_miss = data_valid && (r_state == LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_pred      <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_lock_lost <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      r_lock_lost <= 1'b0;
      if (data_valid) begin
        case (r_state)
          HUNT: begin
            // An all-zero word is the LFSR lock-up state and can never seed a valid sequence.
            if (data_in != 32'h0) begin
              r_pred      <= lfsr_next(data_in);
              r_match_cnt <= '0;
              r_state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_pred <= lfsr_next(r_pred);
              if (w_match_inc == LM) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end else begin
              r_match_cnt <= '0;
              if (data_in == 32'h0) r_state <= HUNT;
              else                  r_pred  <= lfsr_next(data_in);
            end
          end
          LOCKED: begin
            // Flywheel: keep predicting through errors so isolated hits do not cost sync.
            r_pred <= lfsr_next(r_pred);
            if (w_match) begin
              r_miss_cnt <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              if (w_miss_inc == LX) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_lock_lost <= 1'b1;
                r_miss_cnt  <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
      if (clear_cnt)          r_err_count <= '0;
      else if (w_locked_miss) r_err_count <= sat_inc(r_err_count);
    end
  end

`ifdef LFSR_CHK_WORD_CNT_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clk) begin
    if (reset || clear_cnt)                        r_word_count <= '0;
    else if (data_valid && (r_state == LOCKED))    r_word_count <= r_word_count + 32'd1;
  end

  assign word_count = r_word_count;
`endif

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign lock_lost = r_lock_lost;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model queues expected outputs per driven cycle.
`timescale 1ns/1ps
module tb_lfsr_checker;

  localparam int CW = 4;
  localparam logic [31:0] MASK = 32'hB4000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          data_valid = 1'b0;
  logic [31:0]   data_in = '0;
  logic          clear_cnt = 1'b0;
  logic          locked, err_pulse, lock_lost;
  logic [CW-1:0] err_count;
  logic [31:0]   word_count;

  always #5 clk = ~clk;

  lfsr_checker #(.POLY_MASK(MASK), .LOCK_MATCHES(4), .LOSS_MISSES(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .err_count(err_count)
`ifdef LFSR_CHK_WORD_CNT_EN
    , .word_count(word_count)
`endif
  );

`ifndef LFSR_CHK_WORD_CNT_EN
  assign word_count = '0;
`endif

  typedef struct {
    logic          lk;
    logic          ep;
    logic          ll;
    logic [CW-1:0] ec;
    logic [31:0]   wc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
  endfunction

  // Reference model state (0=HUNT, 1=VERIFY, 2=LOCKED)
  int            m_st = 0;
  logic [31:0]   m_pred = '0;
  int            m_mc = 0;
  int            m_xc = 0;
  logic          m_lk = 0, m_ep = 0, m_ll = 0;
  logic [CW-1:0] m_ec = '0;
  logic [31:0]   m_wc = '0;

  task automatic model_step(input logic v, input logic [31:0] d, input logic clr, input logic rst);
    logic mis;
    if (rst) begin
      m_st = 0; m_pred = '0; m_mc = 0; m_xc = 0;
      m_lk = 0; m_ep = 0; m_ll = 0; m_ec = '0; m_wc = '0;
      return;
    end
    m_ep = 0;
    m_ll = 0;
    if (v) begin
      if (m_st == 0) begin
        if (d != 0) begin m_pred = nxt(d); m_mc = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (d == m_pred) begin
          m_pred = nxt(m_pred);
          m_mc++;
          if (m_mc == 4) begin m_st = 2; m_lk = 1; m_xc = 0; m_mc = 0; end
        end else begin
          m_mc = 0;
          if (d == 0) m_st = 0;
          else        m_pred = nxt(d);
        end
      end else begin
        mis = (d != m_pred);
        m_pred = nxt(m_pred);
        m_wc = m_wc + 1;
        if (!mis) m_xc = 0;
        else begin
          m_ep = 1;
          if (m_ec != '1) m_ec = m_ec + 1'b1;
          m_xc++;
          if (m_xc == 8) begin m_st = 0; m_lk = 0; m_ll = 1; m_xc = 0; end
        end
      end
    end
    if (clr) begin m_ec = '0; m_wc = '0; end
  endtask

  // Drive one cycle, queue the model's expectation, then compare after the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic clr, input logic rst);
    exp_t e;
    data_valid = v; data_in = d; clear_cnt = clr; reset = rst;
    model_step(v, d, clr, rst);
    e.lk = m_lk; e.ep = m_ep; e.ll = m_ll; e.ec = m_ec; e.wc = m_wc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("locked", 32'(locked), 32'(e.lk));
      check("err_pulse", 32'(err_pulse), 32'(e.ep));
      check("lock_lost", 32'(lock_lost), 32'(e.ll));
      check("err_count", 32'(err_count), 32'(e.ec));
`ifdef LFSR_CHK_WORD_CNT_EN
      check("word_count", word_count, e.wc);
`endif
    end
  endtask

  logic [31:0] g;

  initial begin
    // Reset state
    @(posedge clk); #1;
    drive(1'b1, 32'h1, 1'b0, 1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);

    // T1 clean lock and 1000 clean words
    g = 32'hACE12345;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, g, 1'b0, 1'b0);
      if (i == 1) check("t1_second_word", g, 32'hE27091A2);
      if (i == 3) check("t1_not_yet_locked", 32'(locked), 32'd0);
      if (i == 4) check("t1_locked_after_5", 32'(locked), 32'd1);
      g = nxt(g);
    end
    check("t1_err_count", 32'(err_count), 32'd0);

    // T2 single bit error
    drive(1'b1, g ^ 32'h1, 1'b0, 1'b0);
    g = nxt(g);
    check("t2_err_pulse", 32'(err_pulse), 32'd1);
    check("t2_err_count", 32'(err_count), 32'd1);
    check("t2_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, g, 1'b0, 1'b0);
      g = nxt(g);
    end
    check("t2_err_after", 32'(err_count), 32'd1);

    // T3 loss of lock after 8 bad words, then relock
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h12345678, 1'b0, 1'b0);
      g = nxt(g);
      if (i == 6) check("t3_still_locked", 32'(locked), 32'd1);
    end
    check("t3_lock_lost", 32'(lock_lost), 32'd1);
    check("t3_err_pulse_last", 32'(err_pulse), 32'd1);
    check("t3_unlocked", 32'(locked), 32'd0);
    check("t3_err_count", 32'(err_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, g, 1'b0, 1'b0);
      if (i == 3) check("t3_relock_pending", 32'(locked), 32'd0);
      if (i == 4) check("t3_relocked", 32'(locked), 32'd1);
      g = nxt(g);
    end

    // T4 zero words in HUNT, then gapped stream
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h0, 1'b0, 1'b0);
    check("t4_zero_hunt", 32'(locked), 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, g, 1'b0, 1'b0);
      if (i == 4) check("t4_gap_locked", 32'(locked), 32'd1);
      g = nxt(g);
      drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    end
    check("t4_err_count", 32'(err_count), 32'd0);

    // T5 saturation with interleaved errors, then clear beats a coincident error
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, g ^ 32'h80, 1'b0, 1'b0);
      g = nxt(g);
      drive(1'b1, g, 1'b0, 1'b0);
      g = nxt(g);
    end
    check("t5_saturated", 32'(err_count), 32'hF);
    check("t5_still_locked", 32'(locked), 32'd1);
    drive(1'b1, g ^ 32'h1, 1'b1, 1'b0);
    g = nxt(g);
    check("t5_clear_priority", 32'(err_count), 32'd0);
    check("t5_clear_pulse", 32'(err_pulse), 32'd1);
    check("t5_clear_keeps_lock", 32'(locked), 32'd1);

    // T6 reset while locked with nonzero counters
    drive(1'b1, g ^ 32'h4, 1'b0, 1'b0);
    g = nxt(g);
    check("t6_pre_err", 32'(err_count), 32'd1);
    drive(1'b1, g, 1'b0, 1'b1);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_err_count", 32'(err_count), 32'd0);
    check("t6_word_count", word_count, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
